// File: rtl/majority_monitor.sv
// majority_monitor: per-channel disagreement tracking, voter sanity check and redundancy state for a 3:1 voter
module majority_monitor #(
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W = 3,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             x0,
  input  logic             x1,
  input  logic             x2,
  input  logic             y,
  output logic [2:0]       fault,
  output logic             voter_err,
  output logic [1:0]       state,
  output logic             alarm,
  output logic [EVT_W-1:0] evt_cnt
);
  typedef enum logic [1:0] {OK = 2'b00, DEGRADED = 2'b01, FAILED = 2'b10} state_t;
  localparam logic [CNT_W:0] THR = FAULT_THRESH[CNT_W:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [EVT_W-1:0] EVT_MAX = '1;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0] fault_q, fault_d, mis;
  logic verr_q, verr_d, any_mis, multi_mis, multi_fault;
  logic [EVT_W-1:0] evt_q, evt_d;
  state_t state_q, state_d;
  always_comb begin
    mis = sample_en ? ({x2, x1, x0} ^ {3{y}}) : 3'b000;
    any_mis = |mis;
    multi_mis = (mis[0] & mis[1]) | (mis[0] & mis[2]) | (mis[1] & mis[2]);
    fault_d = fault_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = !sample_en ? cnt_q[i] : !mis[i] ? '0 : cnt_q[i] == CNT_MAX ? cnt_q[i] : cnt_q[i] + 1'b1;
      fault_d[i] = fault_q[i] | (mis[i] & (({1'b0, cnt_q[i]} + 1'b1) >= THR));
    end
    verr_d = verr_q | multi_mis;
    evt_d = (any_mis && evt_q != EVT_MAX) ? evt_q + 1'b1 : evt_q;
    if (clear) begin
      for (int i = 0; i < 3; i++) cnt_d[i] = '0;
      fault_d = '0;
      verr_d = 1'b0;
      evt_d = '0;
    end
    multi_fault = (fault_d[0] & fault_d[1]) | (fault_d[0] & fault_d[2]) | (fault_d[1] & fault_d[2]);
    state_d = (verr_d || multi_fault) ? FAILED : (|fault_d) ? DEGRADED : OK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      fault_q <= '0;
      verr_q <= 1'b0;
      evt_q <= '0;
      state_q <= OK;
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      fault_q <= fault_d;
      verr_q <= verr_d;
      evt_q <= evt_d;
      state_q <= state_d;
    end
  end
  assign fault = fault_q;
  assign voter_err = verr_q;
  assign state = state_q;
  assign alarm = state_q == FAILED;
  assign evt_cnt = evt_q;
endmodule

// File: tb/tb_majority_monitor.sv
// tb_majority_monitor: scoreboard bench for majority_monitor against a behavioural run-length model
module tb_majority_monitor;
  logic clk = 1'b0, rst, clear, sample_en, x0, x1, x2, y;
  logic [2:0] fault;
  logic voter_err, alarm;
  logic [1:0] state;
  logic [7:0] evt_cnt;
  typedef struct packed {
    logic [2:0] f;
    logic v;
    logic [1:0] s;
    logic a;
    logic [7:0] e;
  } exp_t;
  exp_t sb [$];
  int n_vec = 0, n_err = 0;
  int run [3];
  bit [2:0] mf;
  bit mv;
  int me;
  majority_monitor dut (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .x0(x0), .x1(x1), .x2(x2), .y(y),
    .fault(fault), .voter_err(voter_err), .state(state), .alarm(alarm), .evt_cnt(evt_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input bit r, input bit c, input bit e, input bit [2:0] xv, input bit yv);
    bit [2:0] m;
    exp_t ex, got;
    int nf;
    rst = r; clear = c; sample_en = e; {x2, x1, x0} = xv; y = yv;
    if (r || c) begin
      run = '{0, 0, 0}; mf = '0; mv = 0; me = 0;
    end else if (e) begin
      m = xv ^ {3{yv}};
      for (int i = 0; i < 3; i++) begin
        run[i] = m[i] ? run[i] + 1 : 0;
        if (run[i] >= 4) mf[i] = 1'b1;
      end
      if ($countones(m) >= 2) mv = 1'b1;
      if ($countones(m) >= 1 && me < 255) me++;
    end
    nf = $countones(mf);
    ex.f = mf;
    ex.v = mv;
    ex.s = (mv || nf >= 2) ? 2'b10 : (nf == 1) ? 2'b01 : 2'b00;
    ex.a = ex.s == 2'b10;
    ex.e = 8'(me);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got = {fault, voter_err, state, alarm, evt_cnt};
    ex = sb.pop_front();
    chk("fault", 32'(got.f), 32'(ex.f));
    chk("voter_err", 32'(got.v), 32'(ex.v));
    chk("state", 32'(got.s), 32'(ex.s));
    chk("alarm", 32'(got.a), 32'(ex.a));
    chk("evt_cnt", 32'(got.e), 32'(ex.e));
  endtask
  task automatic do_reset();
    repeat (2) drive(1, 0, 1'($urandom), 3'($urandom), 1'($urandom));
  endtask
  initial begin
    do_reset();
    chk("rst_fault", 32'(fault), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_evt", 32'(evt_cnt), 0);
    repeat (3) drive(0, 0, 1, 3'b110, 1);
    chk("thr_minus1_fault", 32'(fault), 0);
    drive(0, 0, 1, 3'b110, 1);
    chk("single_fault", 32'(fault), 32'b001);
    chk("single_state", 32'(state), 32'b01);
    chk("single_alarm", 32'(alarm), 0);
    chk("single_evt", 32'(evt_cnt), 4);
    repeat (4) drive(0, 0, 1, 3'b011, 1);
    chk("second_fault", 32'(fault), 32'b101);
    chk("second_state", 32'(state), 32'b10);
    chk("second_alarm", 32'(alarm), 1);
    chk("second_evt", 32'(evt_cnt), 8);
    do_reset();
    repeat (2) drive(0, 0, 1, 3'b110, 1);
    repeat (5) drive(0, 0, 0, 3'($urandom), 1'($urandom));
    drive(0, 0, 1, 3'b110, 1);
    drive(0, 0, 1, 3'b111, 1);
    repeat (3) drive(0, 0, 1, 3'b110, 1);
    chk("broken_fault", 32'(fault), 0);
    chk("broken_state", 32'(state), 0);
    chk("broken_evt", 32'(evt_cnt), 6);
    do_reset();
    drive(0, 0, 1, 3'b011, 0);
    chk("verr", 32'(voter_err), 1);
    chk("verr_state", 32'(state), 32'b10);
    chk("verr_fault", 32'(fault), 0);
    chk("verr_evt", 32'(evt_cnt), 1);
    do_reset();
    repeat (300) drive(0, 0, 1, 3'b101, 1);
    chk("sat_evt", 32'(evt_cnt), 255);
    chk("sat_fault", 32'(fault), 32'b010);
    drive(0, 1, 1, 3'b101, 1);
    chk("clr_evt", 32'(evt_cnt), 0);
    chk("clr_fault", 32'(fault), 0);
    chk("clr_state", 32'(state), 0);
    repeat (3) drive(0, 0, 1, 3'b101, 1);
    chk("clr_restart", 32'(fault), 0);
    for (int k = 0; k < 400; k++) begin
      bit [2:0] xv;
      bit yv;
      yv = 1'($urandom);
      xv = {3{yv}};
      if ($urandom_range(0, 2) == 0) xv[$urandom_range(0, 2)] ^= 1'b1;
      if ($urandom_range(0, 30) == 0) xv = 3'($urandom);
      drive($urandom_range(0, 80) == 0, $urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, xv, yv);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/majority_monitor.md
# majority_monitor

Health monitor that sits directly downstream of the 3:1 majority voter. Each sample, it compares the three redundant channel inputs against the voter's output and tracks consecutive per-channel disagreements. A channel that disagrees persistently is declared faulty. The block also flags a voter that contradicts its own inputs and reports an overall redundancy state: OK, DEGRADED or FAILED.

## Interface
Parameters:
- FAULT_THRESH, default 4: consecutive mismatching samples that declare a channel faulty. Legal range 1 .. 2^CNT_W-1.
- CNT_W, default 3: width of each per-channel consecutive-mismatch counter.
- EVT_W, default 8: width of the disagreement event counter.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  reset, synchronous, active-high
- clear  in  1  synchronous clear of all monitor state; same effect as rst
- sample_en  in  1  qualifies x0/x1/x2/y as one valid sample this cycle
- x0, x1, x2  in  1 each  redundant channel inputs, the same signals that feed the voter
- y  in  1  voter output for the same sample
- fault  out  3  sticky per-channel fault flags; bit i corresponds to channel xi
- voter_err  out  1  sticky: y disagreed with two or more channels
- state  out  2  2'b00 OK, 2'b01 DEGRADED, 2'b10 FAILED; 2'b11 never driven
- alarm  out  1  high exactly when state == FAILED
- evt_cnt  out  EVT_W  saturating count of samples in which at least one channel disagreed with y

## Operation
- Per-channel mismatch: mis_i = xi ^ y, evaluated only when sample_en = 1.
- Per-channel counter miss_cnt_i:
  - If mis_i = 1, increment, saturating at 2^CNT_W-1.
  - If mis_i = 0, reset to 0, so only consecutive mismatches count.
  - Cycles with sample_en = 0 hold the counter and do not break the run.
- Fault declaration:
  - fault[i] is set on the sample in which miss_cnt_i+1 >= FAULT_THRESH.
  - fault[i] is sticky. Only rst or clear removes it.
  - A faulted channel's counter keeps running; the counter has no effect once the fault is set.
- Voter check: if popcount(mis) >= 2 on a sample, voter_err is set (sticky). In that same sample, the mismatch counters still update normally.
- evt_cnt: increments by 1 on each sample with popcount(mis) >= 1. It saturates at 2^EVT_W-1 and never wraps.
- State machine, with next state computed from the next values of fault and voter_err:
  - FAILED if voter_err = 1 or popcount(fault) >= 2.
  - Otherwise DEGRADED if popcount(fault) = 1.
  - Otherwise OK.
  - Transitions are monotonic: OK→DEGRADED, OK→FAILED, DEGRADED→FAILED. The only exit from DEGRADED or FAILED is rst or clear.
- alarm is decoded from the state register. It is glitch-free and adds no extra latency.
- Priority, highest first: rst, then clear, then sample_en. A sample presented in the same cycle as clear is discarded.

## Timing
- Reset or clear values, visible after the clocking edge: fault = 3'b000, voter_err = 0, state = OK, alarm = 0, evt_cnt = 0, all miss_cnt_i = 0.
- Latency: one clock. A sample presented at edge N updates fault, voter_err, state, alarm and evt_cnt, all visible after edge N.
  - fault and state change on the same edge; no cycle shows a new fault with a stale state.
- A channel that mismatches on FAULT_THRESH consecutive samples has fault[i] set after the edge of the FAULT_THRESH-th sample. With FAULT_THRESH = 1, the first mismatch faults the channel.
- A correctly operating voter mismatches at most one channel per sample. Two channels therefore fault on different samples, except through voter_err, which drives state directly to FAILED.
- Idle cycles (sample_en = 0) leave every output and counter unchanged.
- Reset or clear in the middle of a mismatch run discards the partial count. A subsequent run restarts from 0.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → fault = 000, voter_err = 0, state = 00, alarm = 0, evt_cnt = 0.
- Single-channel fault: 4 samples of {x2,x1,x0} = 3'b110 with y = 1 → after the 4th edge fault = 001, state = 01, alarm = 0, evt_cnt = 4. After the 3rd edge fault is still 000.
- Run broken by a match: x0 mismatches 3 samples, matches 1 sample, mismatches 3 samples, with 5 idle cycles inserted mid-run → fault = 000, state = 00, evt_cnt = 6.
- Second fault: from the single-channel-fault end state, 4 samples of {x2,x1,x0} = 3'b011 with y = 1 → fault = 101, state = 10, alarm = 1, evt_cnt = 8.
- Voter error: single sample {x2,x1,x0} = 3'b011 with y = 0 → after 1 edge voter_err = 1, state = 10, alarm = 1, evt_cnt = 1, fault = 000.
- Clear and saturation:
  - With EVT_W = 8, apply 300 samples with x1 mismatching → evt_cnt = 255, not wrapped.
  - Then assert clear and sample_en together with a mismatching sample → all outputs return to reset values and evt_cnt = 0.
